// File: rtl/regfile_dump_if.sv
// Beat stream from the register-file dump engine to a debug/trace consumer.
// Each beat carries one {register number, register contents} pair under valid/ready.
interface regfile_dump_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump.sv
// Walks a contiguous, optionally wrapping, register range through one register-file
// read port and streams {address, data} beats out, one beat per two cycles at best.
module regfile_dump #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  first_addr,
  input  logic [ADDR_W-1:0]  last_addr,
  output logic               busy,
  output logic [ADDR_W-1:0]  rf_addr,
  input  logic [DATA_W-1:0]  rf_data,
  regfile_dump_if.master     beat,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] cur_r, cur_s;
  logic [ADDR_W-1:0] end_r, end_s;
  logic [ADDR_W-1:0] rf_addr_r, rf_addr_s;
  logic [ADDR_W-1:0] out_addr_r, out_addr_s;
  logic [DATA_W-1:0] out_data_r, out_data_s;
  logic              out_last_r, out_last_s;
  logic              out_valid_r, out_valid_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [ADDR_W-1:0] cur_inc_s;

  assign cur_inc_s = cur_r + ADDR_W'(1);

  // Next-state and next-output decode; abort always wins over start and handshake.
  always_comb begin
    state_s     = state_r;
    cur_s       = cur_r;
    end_s       = end_r;
    rf_addr_s   = rf_addr_r;
    out_addr_s  = out_addr_r;
    out_data_s  = out_data_r;
    out_last_s  = out_last_r;
    out_valid_s = out_valid_r;
    busy_s      = busy_r;
    done_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          cur_s     = first_addr;
          end_s     = last_addr;
          rf_addr_s = first_addr;
          busy_s    = 1'b1;
          state_s   = ST_ISSUE;
        end else begin
          state_s   = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        if (abort) begin
          busy_s      = 1'b0;
          out_valid_s = 1'b0;
          out_last_s  = 1'b0;
          state_s     = ST_IDLE;
        end else begin
          // rf_data settled on the falling edge inside this cycle
          out_data_s  = rf_data;
          out_addr_s  = cur_r;
          out_last_s  = (cur_r == end_r);
          out_valid_s = 1'b1;
          state_s     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (abort) begin
          busy_s      = 1'b0;
          out_valid_s = 1'b0;
          out_last_s  = 1'b0;
          state_s     = ST_IDLE;
        end else if (beat.out_ready) begin
          out_valid_s = 1'b0;
          if (out_last_r) begin
            out_last_s = 1'b0;
            busy_s     = 1'b0;
            done_s     = 1'b1;
            state_s    = ST_IDLE;
          end else begin
            cur_s      = cur_inc_s;
            rf_addr_s  = cur_inc_s;
            state_s    = ST_ISSUE;
          end
        end else begin
          state_s     = ST_SEND;
        end
      end

      default: begin
        busy_s      = 1'b0;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        state_s     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any dump in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cur_r       <= {ADDR_W{1'b0}};
      end_r       <= {ADDR_W{1'b0}};
      rf_addr_r   <= {ADDR_W{1'b0}};
      out_addr_r  <= {ADDR_W{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cur_r       <= cur_s;
      end_r       <= end_s;
      rf_addr_r   <= rf_addr_s;
      out_addr_r  <= out_addr_s;
      out_data_r  <= out_data_s;
      out_last_r  <= out_last_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign busy           = busy_r;
  assign rf_addr        = rf_addr_r;
  assign done           = done_r;
  assign beat.out_valid = out_valid_r;
  assign beat.out_addr  = out_addr_r;
  assign beat.out_data  = out_data_r;
  assign beat.out_last  = out_last_r;

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Debug read-out engine for the CPU register file. On command, it walks a contiguous (optionally wrapping) range of register addresses through one register-file read port.
- It drives the port's read address, captures the returned data, and streams {address, data} beats out over a valid/ready interface to a debug/trace consumer.
- It sits beside the register file, muxed onto a read port while the core is halted.

Parameters:
- ADDR_W, 5, register address width (32 registers)
- DATA_W, 32, register data width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle dump request; sampled only when busy=0
- abort  input  1  synchronous cancel of a dump in progress
- first_addr  input  ADDR_W  first register of range, latched on accepted start
- last_addr  input  ADDR_W  last register of range, latched on accepted start
- busy  output  1  high from accepted start until completion or abort
- rf_addr  output  ADDR_W  read address to register-file read port (registered)
- rf_data  input  DATA_W  read data from that port; valid after the falling edge following an rf_addr change
- out_valid  output  1  beat valid
- out_ready  input  1  consumer accepts beat
- out_addr  output  ADDR_W  register number of current beat
- out_data  output  DATA_W  register contents of current beat
- out_last  output  1  marks final beat of the dump
- done  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, out_valid, out_last and done are 0. rf_addr, out_addr and out_data are 0. Internal current/last registers are 0. Reset mid-dump discards everything; no done.
- States: IDLE, ISSUE, SEND.
- IDLE: start=1 at edge E0 latches cur=first_addr and end=last_addr, sets rf_addr=first_addr and busy=1, and goes to ISSUE. Otherwise it stays in IDLE.
- ISSUE (exactly 1 cycle):
  - rf_addr is stable; the register file updates rf_data on the falling edge inside this cycle.
  - At the next rising edge, rf_data is captured into out_data, cur goes to out_addr, out_last=(cur==end), out_valid=1, and the state goes to SEND.
- SEND: out_valid=1; out_addr, out_data and out_last are held stable until handshake (out_valid & out_ready at a rising edge).
  - On handshake with out_last=1: out_valid=0, busy=0, done=1 for exactly one cycle, then IDLE.
  - On handshake with out_last=0: cur=cur+1 modulo 2^ADDR_W (31 wraps to 0), rf_addr=cur+1, out_valid=0, then ISSUE.
- Range rules:
  - Beat count = ((end - first) mod 2^ADDR_W) + 1.
  - first==end gives exactly 1 beat.
  - end<first wraps through register 31 to 0 (e.g. 30..1 gives 30, 31, 0, 1).
- Throughput: with out_ready held high, there is one beat per 2 cycles. Minimum latency is start edge to out_valid = 1 cycle.
- Data: rf_data is passed unmodified; register 0 is reported as whatever the port returns.
- start while busy=1: ignored, no effect on latched range.
- abort=1 at a rising edge while busy: next state IDLE. busy, out_valid and out_last are cleared; done is not asserted. abort overrides a coincident handshake. abort in IDLE: no effect. abort and start together in IDLE: start is ignored.
- done and out_valid are never high in the same cycle.
- rf_addr holds its last value in IDLE.

Test Plan:
- Full dump: first=0, last=31, out_ready=1, register k preloaded with 0xA5000000+k.
  - 32 beats at edges E2, E4, ..., E64 with out_addr=k and out_data=0xA5000000+k.
  - out_last only on beat 31; done high for the single cycle after E64; busy low after E64.
- Backpressure: first=5, last=7, out_ready low for 3 cycles on each beat.
  - out_addr, out_data and out_last are stable while stalled.
  - Exactly 3 beats (5, 6, 7); no duplicates or drops.
- Wrap and single: first=30, last=1 gives beats 30, 31, 0, 1 with last on 1. first=last=9 gives one beat, addr 9, out_last=1, then done.
- Abort: start 0..31, assert abort during SEND of beat 4 with out_ready=1.
  - No handshake counted for beat 4; out_valid=0 and busy=0 next cycle; done never asserted.
  - A new start 2..3 then works normally.
- Start while busy: pulse start with first=20 during a 0..3 dump. The dump still ends at register 3 with 4 beats.
- Async reset mid-SEND: drop rst_n between edges.
  - busy, out_valid and rf_addr go to 0 immediately, without a clock.
  - After release, the block is IDLE and a fresh dump completes correctly.
